// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction-fetch front end.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Circular-buffer FIFO with occupancy count, synchronous flush and reset.
// Data storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush overrides both push and pop in the same cycle.
    assign push_ok = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i  && !flush_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited memory
// requests, buffers in-order responses with their PCs, handles redirect and ebreak halt.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [WIDTH-1:0] req_addr_o,
    input  logic             resp_valid_i,
    input  logic [WIDTH-1:0] resp_data_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] inst_pc_o,
    output logic             ebreak_o,
    output logic             halted_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic             halted_q, halted_d;

    logic [CW-1:0]      q_count;
    logic               q_valid;
    logic [2*WIDTH-1:0] q_head;
    logic [WIDTH-1:0]   head_inst;
    logic [WIDTH-1:0]   head_pc;
    logic               head_valid;
    logic               head_is_ebreak;
    logic [CW:0]        inflight;
    logic               credit_ok;
    logic               req_fire;
    logic               pop;
    logic               push;
    logic               flush;

    // Queue entries plus requests in flight (including ones to be dropped) never exceed DEPTH.
    assign inflight  = {1'b0, q_count} + {1'b0, outstanding_q};
    assign credit_ok = inflight < (CW+1)'(DEPTH);

    assign req_valid_o = !rst && !halted_q && !redirect_valid_i && credit_ok;
    assign req_fire    = req_valid_o && req_ready_i;
    assign req_addr_o  = rst ? RESET_PC : fetch_pc_q;

    assign head_pc        = q_head[2*WIDTH-1:WIDTH];
    assign head_inst      = q_head[WIDTH-1:0];
    assign head_valid     = q_valid && !halted_q && !rst;
    assign head_is_ebreak = (head_inst == WIDTH'(EBREAK_INST));
    assign pop            = head_valid && inst_ready_i;

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head_inst : '0;
    assign inst_pc_o    = head_valid ? head_pc   : '0;
    assign ebreak_o     = head_valid && head_is_ebreak;
    assign halted_o     = halted_q && !rst;

    // Stale, redirect-cycle and post-halt responses never enter the queue.
    assign push  = resp_valid_i && (drop_q == '0) && !redirect_valid_i && !halted_q;
    assign flush = redirect_valid_i || halted_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_valid_i);
        drop_d        = drop_q;
        halted_d      = halted_q;

        if (resp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
        if (push)                            resp_pc_d = resp_pc_q + WIDTH'(4);
        if (req_fire)                        fetch_pc_d = fetch_pc_q + WIDTH'(4);
        if (pop && head_is_ebreak)           halted_d = 1'b1;

        // No request fires during redirect, so everything still outstanding afterwards is stale.
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            drop_d     = outstanding_q - CW'(resp_valid_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
        end
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  ({resp_pc_q, resp_data_i}),
        .pop_i   (pop),
        .valid_o (q_valid),
        .data_o  (q_head),
        .count_o (q_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench: transaction-level memory and expected-instruction queue model
// drive and check fetch_queue under directed scenarios and a random soak.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_o, req_ready_i;
    logic [31:0] req_addr_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o, inst_pc_o;
    logic        ebreak_o, halted_o;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .resp_valid_i     (resp_valid_i),
        .resp_data_i      (resp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .ebreak_o         (ebreak_o),
        .halted_o         (halted_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  m_pc;
    logic [31:0]  ebreak_addr;
    int           gen, cyc, n_vec, n_err;
    bit           m_halt, saw_wrap;
    int           lat_min, lat_max, rdy_pct, dec_pct, redir_pm;
    int           fires, halt_fires;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == ebreak_addr) return EBREAK_INST;
        w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        if (w == EBREAK_INST) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step(input bit do_rst, input bit force_redir, input logic [31:0] tgt);
        bit           fire, pop, rsp, redir, halt_next;
        fetch_entry_t e;
        mreq_t        m;
        int           due;
        @(negedge clk);
        rst          = do_rst;
        req_ready_i  = ($urandom_range(99) < rdy_pct);
        inst_ready_i = ($urandom_range(99) < dec_pct);
        redir        = !do_rst && (force_redir || ($urandom_range(999) < redir_pm));
        redirect_valid_i = redir;
        if (force_redir)
            redirect_pc_i = tgt;
        else case ($urandom_range(2))
            0:       redirect_pc_i = 32'h8000_0100;
            1:       redirect_pc_i = 32'hFFFF_FFF8;
            default: redirect_pc_i = $urandom & 32'hFFFF_FFFC;
        endcase
        rsp          = !do_rst && (mq.size() > 0) && (mq[0].due <= cyc);
        resp_valid_i = rsp;
        resp_data_i  = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        if (do_rst) begin
            chk("rst_req_valid", req_valid_o, 0);
            chk("rst_req_addr", req_addr_o, RPC);
            chk("rst_inst_valid", inst_valid_o, 0);
            chk("rst_inst", inst_o, 0);
            chk("rst_inst_pc", inst_pc_o, 0);
            chk("rst_ebreak", ebreak_o, 0);
            chk("rst_halted", halted_o, 0);
            mq.delete();
            exp_q.delete();
            m_pc   = RPC;
            gen    = 0;
            m_halt = 0;
        end else begin
            chk("halted", halted_o, m_halt);
            chk("inst_valid", inst_valid_o, (exp_q.size() > 0) && !m_halt);
            if (inst_valid_o && exp_q.size() > 0) begin
                chk("inst_pc", inst_pc_o, exp_q[0].pc);
                chk("inst", inst_o, exp_q[0].inst);
                chk("ebreak", ebreak_o, exp_q[0].inst == EBREAK_INST);
            end
            chk("req_valid", req_valid_o, !m_halt && !redir && (exp_q.size() + mq.size() < DEPTH));
            if (req_valid_o) chk("req_addr", req_addr_o, m_pc);

            fire      = req_valid_o && req_ready_i;
            pop       = inst_valid_o && inst_ready_i && (exp_q.size() > 0);
            halt_next = m_halt;
            if (fire) begin
                fires++;
                if (m_halt) halt_fires++;
                if (req_addr_o == 32'h0) saw_wrap = 1;
            end
            if (pop) begin
                e = exp_q.pop_front();
                if (e.inst == EBREAK_INST) halt_next = 1;
            end
            if (rsp) begin
                m = mq.pop_front();
                if (m.gen == gen && !redir && !m_halt) begin
                    e.pc   = m.addr;
                    e.inst = mem_word(m.addr);
                    exp_q.push_back(e);
                end
            end
            if (fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
                m.addr = req_addr_o;
                m.gen  = gen;
                m.due  = due;
                mq.push_back(m);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                gen++;
                m_pc = redirect_pc_i;
            end
            m_halt = halt_next;
            if (m_halt) exp_q.delete();
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_ready_i = 0; resp_valid_i = 0; resp_data_i = 0;
        redirect_valid_i = 0; redirect_pc_i = 0; inst_ready_i = 0;
        n_vec = 0; n_err = 0; cyc = 0; fires = 0; halt_fires = 0; saw_wrap = 0;
        gen = 0; m_halt = 0; m_pc = RPC;
        ebreak_addr = 32'h0000_0002;
        lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100; redir_pm = 0;

        // Streaming with single-cycle memory and always-ready decode.
        do_reset(3);
        run(20);

        // Decode stalled: credit stops issue after DEPTH requests, then resumes.
        do_reset(2);
        dec_pct = 0; fires = 0;
        run(12);
        chk("stall_issue_count", fires, DEPTH);
        dec_pct = 100;
        run(20);

        // Three-cycle memory, redirect with requests in flight.
        do_reset(2);
        lat_min = 3; lat_max = 3;
        run(5);
        step(0, 1, 32'h8000_0100);
        run(20);

        // Steady state: redirect coincides with a response and a head handshake.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        run(8);
        step(0, 1, 32'h8000_0400);
        run(8);

        // Ebreak at 8000_000C halts fetch until reset.
        ebreak_addr = 32'h8000_000C;
        do_reset(2);
        halt_fires = 0;
        run(25);
        chk("halted_after_ebreak", halted_o, 1);
        chk("req_after_halt", halt_fires, 0);
        ebreak_addr = 32'h0000_0002;

        // PC wrap past the top of the address space.
        do_reset(2);
        saw_wrap = 0;
        step(0, 1, 32'hFFFF_FFF0);
        run(12);
        chk("pc_wrap_seen", saw_wrap, 1);

        // Random soak: backpressure, variable latency, random redirects.
        do_reset(2);
        lat_min = 1; lat_max = 4; rdy_pct = 70; dec_pct = 70; redir_pm = 40;
        run(3000);

        // Random soak including an ebreak somewhere in a short loop.
        ebreak_addr = 32'h8000_0010;
        do_reset(2);
        redir_pm = 0;
        run(60);
        chk("halted_after_soak_ebreak", halted_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
